// File: rtl/reg_file_param.sv
// Parameterised two-read / one-write register file with a sweep-clear FSM.
// Reads are combinational. clr_req starts a sweep that zeroes one entry per
// cycle. Writes that arrive while a sweep is running are dropped and flagged
// on wr_err.
// Optional feature: define REG_FILE_PARAM_BYPASS_EN to forward same-cycle
// write data onto a read port whose address matches the write address.
//
// state | meaning
// IDLE  | accepting writes, waiting for clr_req
// CLEAR | zeroing reg[ptr] each cycle, busy high, writes dropped
// DONE  | sweep finished, clr_done pulses for one cycle
module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [WIDTH-1:0]  rd_data0,
    output logic [WIDTH-1:0]  rd_data1,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_err
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic              r_clr_done;
    logic              r_wr_err;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_wr_zero_addr;
    logic              w_wr_ok;

    // Writes to a hardwired-zero register 0 are discarded without an error.
    assign w_wr_zero_addr = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_wr_ok        = wr_en && !r_busy && !w_wr_zero_addr;

    assign busy     = r_busy;
    assign clr_done = r_clr_done;
    assign wr_err   = r_wr_err;

    // Clear-sweep FSM with registered busy / clr_done / wr_err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            r_wr_err   <= wr_en && r_busy;
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Stop on the last entry rather than letting ptr roll over.
                    if (r_ptr == LAST_ADDR) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep zeroing has priority; writes only land when not busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports, with optional same-cycle write forwarding.
    always_comb begin
        rd_data0 = r_mem[rd_addr0];
        rd_data1 = r_mem[rd_addr1];
        if ((ZERO_REG != 0) && (rd_addr0 == '0)) begin
            rd_data0 = '0;
        end
        if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end
`ifdef REG_FILE_PARAM_BYPASS_EN
        if (w_wr_ok && (rd_addr0 == wr_addr)) begin
            rd_data0 = wr_data;
        end
        if (w_wr_ok && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: default 32x32 instance plus an
// 8-entry, 8-bit instance for the small-geometry sweep.
module tb_reg_file_param;

    logic        clk;
    logic        rst;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
    logic        wr_err;

    logic        s_wr_en;
    logic [2:0]  s_wr_addr;
    logic [7:0]  s_wr_data;
    logic [2:0]  s_rd_addr0;
    logic [2:0]  s_rd_addr1;
    logic [7:0]  s_rd_data0;
    logic [7:0]  s_rd_data1;
    logic        s_clr_req;
    logic        s_busy;
    logic        s_clr_done;
    logic        s_wr_err;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eerr;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eerr;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    exp_t ex;

    int          busy_cnt;
    int          guard;
    int          done_seen;
    logic [31:0] acc;

    reg_file_param dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .wr_err   (wr_err)
    );

    reg_file_param #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (s_wr_en),
        .wr_addr  (s_wr_addr),
        .wr_data  (s_wr_data),
        .rd_addr0 (s_rd_addr0),
        .rd_addr1 (s_rd_addr1),
        .rd_data0 (s_rd_data0),
        .rd_data1 (s_rd_data1),
        .clr_req  (s_clr_req),
        .busy     (s_busy),
        .clr_done (s_clr_done),
        .wr_err   (s_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 5'd31, 32'hA5A50001, 5'd31, 5'd7,  32'hA5A50001, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 5'd1,  32'h00000011, 5'd1,  5'd31, 32'h00000011, 32'hA5A50001, 1'b0};
        vecs[4] = '{1'b0, 5'd7,  32'hFFFFFFFF, 5'd7,  5'd1,  32'hDEADBEEF, 32'h00000011, 1'b0};
        vecs[5] = '{1'b1, 5'd7,  32'h00000001, 5'd7,  5'd0,  32'h00000001, 32'h0,        1'b0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd12, 5'd31, 32'h0,        32'hA5A50001, 1'b0};

        rst = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = 5'd7; rd_addr1 = 5'd31; clr_req = 1'b0;
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        s_rd_addr0 = '0; s_rd_addr1 = '0; s_clr_req = 1'b0;

        #2;
        chk("reset_rd0", rd_data0, 32'h0);
        chk("reset_rd1", rd_data1, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_clr_done", 32'(clr_done), 32'h0);
        chk("reset_wr_err", 32'(wr_err), 32'h0);

        // Release between edges; the very next edge must take the first write.
        #10;
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            wr_en    = vecs[i].wr_en;
            wr_addr  = vecs[i].wr_addr;
            wr_data  = vecs[i].wr_data;
            rd_addr0 = vecs[i].ra0;
            rd_addr1 = vecs[i].ra1;
            sb.push_back('{i, vecs[i].e0, vecs[i].e1, vecs[i].eerr});
            step();
            ex = sb.pop_front();
            chk($sformatf("vec%0d_rd0", ex.idx), rd_data0, ex.e0);
            chk($sformatf("vec%0d_rd1", ex.idx), rd_data1, ex.e1);
            chk($sformatf("vec%0d_wr_err", ex.idx), 32'(wr_err), 32'(ex.eerr));
        end
        wr_en = 1'b0;

        // Same-cycle visibility depends on the bypass build option.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE; rd_addr0 = 5'd9;
        #1;
`ifdef REG_FILE_PARAM_BYPASS_EN
        chk("bypass_same_cycle", rd_data0, 32'hCAFE);
`else
        chk("no_bypass_old_value", rd_data0, 32'h0);
`endif
        step();
        wr_en = 1'b0;
        chk("write9_after_edge", rd_data0, 32'hCAFE);

        // Fill 1..31 with their own index.
        for (int a = 1; a < 32; a++) begin
            wr_en = 1'b1; wr_addr = a[4:0]; wr_data = 32'(a);
            step();
        end
        wr_en = 1'b0;
        rd_addr0 = 5'd17; rd_addr1 = 5'd31;
        #1;
        chk("fill_rd17", rd_data0, 32'd17);
        chk("fill_rd31", rd_data1, 32'd31);

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt = 0; guard = 0; done_seen = 0;
        while (busy && guard < 200) begin
            busy_cnt++;
            guard++;
            if (busy_cnt == 5) begin
                rd_addr0 = 5'd3; rd_addr1 = 5'd4;
                #1;
                chk("mid_sweep_below_ptr", rd_data0, 32'h0);
                chk("mid_sweep_at_ptr", rd_data1, 32'd4);
                wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
            end
            if (busy_cnt == 6) begin
                chk("wr_err_pulse", 32'(wr_err), 32'h1);
                wr_en = 1'b0;
            end
            if (busy_cnt == 7) chk("wr_err_one_cycle", 32'(wr_err), 32'h0);
            if (busy_cnt == 10) clr_req = 1'b1;
            if (busy_cnt == 11) clr_req = 1'b0;
            if (clr_done) done_seen++;
            step();
        end
        chk("sweep_timeout", 32'(guard >= 200), 32'h0);
        chk("sweep_busy_cycles", busy_cnt, 32'd32);
        chk("no_done_while_busy", done_seen, 32'h0);
        chk("clr_done_pulse", 32'(clr_done), 32'h1);
        step();
        chk("clr_done_one_cycle", 32'(clr_done), 32'h0);
        step();
        chk("clr_req_not_queued", 32'(busy), 32'h0);

        acc = '0;
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = a[4:0];
            rd_addr1 = 5'(31 - a);
            #1;
            acc = acc | rd_data0 | rd_data1;
        end
        chk("all_zero_after_sweep", acc, 32'h0);
        rd_addr0 = 5'd2;
        #1;
        chk("dropped_write_not_stored", rd_data0, 32'h0);

        // Write and clr_req together in IDLE: write lands, then gets swept.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h99; clr_req = 1'b1;
        step();
        wr_en = 1'b0; clr_req = 1'b0; rd_addr0 = 5'd5;
        #1;
        chk("simul_write_committed", rd_data0, 32'h99);
        chk("simul_busy", 32'(busy), 32'h1);
        guard = 0;
        while (busy && guard < 200) begin
            guard++;
            step();
        end
        chk("simul_sweep_timeout", 32'(guard >= 200), 32'h0);
        chk("simul_write_cleared", rd_data0, 32'h0);

        // Reset in the middle of a sweep.
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h55;
        step();
        wr_en = 1'b0; rd_addr0 = 5'd20; rd_addr1 = 5'd31;
        #1;
        chk("pre_reset_rd20", rd_data0, 32'h55);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 1; k < 10; k++) step();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_rd20", rd_data0, 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_clr_done", 32'(clr_done), 32'h0);
        chk("async_rst_wr_err", 32'(wr_err), 32'h0);
        done_seen = 0;
        repeat (3) begin
            step();
            if (clr_done) done_seen++;
        end
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5; rd_addr0 = 5'd3;
        step();
        wr_en = 1'b0;
        chk("post_reset_write", rd_data0, 32'hA5);
        chk("post_reset_idle", 32'(busy), 32'h0);
        repeat (40) begin
            if (clr_done || busy) done_seen++;
            step();
        end
        chk("aborted_sweep_no_done", done_seen, 32'h0);

        // Small geometry: 8 entries of 8 bits.
        s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 8'hFF;
        step();
        s_wr_en = 1'b0; s_rd_addr0 = 3'd7;
        #1;
        chk("small_rd7", 32'(s_rd_data0), 32'hFF);
        s_wr_en = 1'b1; s_wr_addr = 3'd0; s_wr_data = 8'hAB;
        step();
        s_wr_en = 1'b0; s_rd_addr1 = 3'd0;
        #1;
        chk("small_zero_reg", 32'(s_rd_data1), 32'h0);
        chk("small_zero_wr_err", 32'(s_wr_err), 32'h0);
        s_clr_req = 1'b1;
        step();
        s_clr_req = 1'b0;
        busy_cnt = 0; guard = 0;
        while (s_busy && guard < 100) begin
            busy_cnt++;
            guard++;
            step();
        end
        chk("small_sweep_cycles", busy_cnt, 32'd8);
        chk("small_clr_done", 32'(s_clr_done), 32'h1);
        chk("small_rd7_cleared", 32'(s_rd_data0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits of every register.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have one clock, clk; rst is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 wr_en  input  1  write request, sampled on rising clk.
REQ-008 wr_addr  input  ADDR_W  write address.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 rd_addr0 / rd_addr1  input  ADDR_W  read addresses, ports 0 and 1.
REQ-011 rd_data0 / rd_data1  output  WIDTH  combinational read data, ports 0 and 1.
REQ-012 clr_req  input  1  request to sweep-clear all registers.
REQ-013 busy  output  1  registered; high while a clear sweep is in progress.
REQ-014 clr_done  output  1  registered; one-cycle pulse when a sweep finishes.
REQ-015 wr_err  output  1  registered; one-cycle pulse when a write is dropped.

Function
REQ-016 Reads SHALL be combinational: rd_dataN = reg[rd_addrN], with zero latency.
REQ-017 With ZERO_REG=1, a read of address 0 SHALL return 0, and a write to address 0 SHALL be silently ignored, with no wr_err.
REQ-018 A write SHALL commit on a rising clk when wr_en=1 and busy=0; the data is visible on the read ports after that edge.
REQ-019 A write with wr_en=1 while busy=1 SHALL be dropped, and wr_err SHALL be high for the following cycle.
REQ-020 The clear FSM SHALL have states IDLE, CLEAR and DONE, with an internal pointer ptr of ADDR_W bits.
REQ-021 IDLE: when clr_req=1 is sampled, go to CLEAR, with ptr=0 and busy=1 from the next cycle.
REQ-022 CLEAR: each cycle, reg[ptr] is set to 0 and ptr increments; when ptr=DEPTH-1, go to DONE.
REQ-023 DONE: clr_done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be high for exactly DEPTH consecutive cycles per sweep.
REQ-025 clr_req SHALL be ignored in CLEAR and DONE; it is not queued.
REQ-026 Simultaneous clr_req and wr_en in IDLE: the write commits, and the following sweep then zeroes it.
REQ-027 Reads during CLEAR SHALL return current contents: entries below ptr read 0, the others hold their old values.
REQ-028 ptr SHALL NOT wrap silently; the sweep ends at DEPTH-1 exactly.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for clk, zero all registers, force the FSM to IDLE, and set ptr=0, busy=0, clr_done=0, wr_err=0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep, with no clr_done pulse.
REQ-031 After rst is released, the first rising clk SHALL accept writes and clr_req.

Configuration
REQ-032 Macro REG_FILE_PARAM_BYPASS_EN enables write-to-read bypass on both read ports.
REQ-033 With the macro defined: when wr_en=1, busy=0, rd_addrN=wr_addr, and the address is not a hardwired-zero register 0, rd_dataN SHALL return wr_data in the same cycle.
REQ-034 Without the macro: rd_dataN SHALL return the stored value, and the new data appears only after the write edge.

Verification
REQ-035 Defaults; write 0xDEADBEEF to address 7, then read port 0 at address 7 -> 0xDEADBEEF from the cycle after the edge; read port 1 at address 0 -> 0.
REQ-036 Write 0x12345678 to address 0 with ZERO_REG=1 -> read of address 0 = 0 and wr_err = 0.
REQ-037 Fill addresses 1..31 with their own index, then pulse clr_req -> busy high for 32 cycles, clr_done for 1 cycle, all reads 0; a write attempted in sweep cycle 5 -> wr_err pulse and the data is not stored.
REQ-038 Assert rst=0 at sweep cycle 10 with address 20 holding 0x55 -> all outputs 0 immediately, FSM in IDLE, no clr_done; after release, a write of 0xA5 to address 3 commits.
REQ-039 REG_FILE_PARAM_BYPASS_EN defined; wr_en=1, wr_addr=9, wr_data=0xCAFE, rd_addr0=9 -> rd_data0=0xCAFE in the same cycle; without the macro, the old value until the edge.
REQ-040 WIDTH=8, ADDR_W=3 -> sweep busy lasts 8 cycles; writing 0xFF to address 7 reads back 0xFF.
